// File: rtl/uart_pkg.sv
// Shared UART CRC-link definitions: receiver state encoding and the CRC-8 helper.
// The same CRC function serves as the reference for the TX serial engine.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_CRC,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Bit-serial MSB-first update, the same recurrence the TX engine applies per bit.
    function automatic logic [7:0] crc8_byte(input logic [7:0] data);
        logic [7:0] crc;
        logic       fb;
        crc = CRC8_INIT;
        for (int i = 7; i >= 0; i--) begin
            fb  = crc[7] ^ data[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
        return crc;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, oversample tick counter and bit-centre sampler for the UART receiver.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 vote around the bit centre).
module uart_rx_sampler #(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    input  logic sample_tick_i,
    input  logic clear_i,
    output logic rx_sync_o,
    output logic bit_sample_o,
    output logic bit_val_o
);

    localparam int            CW      = $clog2(OVS);
    localparam logic [CW-1:0] CNT_MAX = CW'(OVS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [CW-1:0]          decide_cnt_s;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], rx_i};
    assign rx_sync_o = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, preset to the idle line level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Tick counter next state: held at zero while idle, wraps once per bit period.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clear_i) begin
            tick_cnt_d = '0;
        end else if (sample_tick_i) begin
            if (tick_cnt_q == CNT_MAX) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + CW'(1);
            end
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
    end

    // Tick counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] VOTE_A = CW'(OVS / 2 - 2);
    localparam logic [CW-1:0] VOTE_B = CW'(OVS / 2 - 1);

    logic [1:0] vote_q, vote_d;

    assign decide_cnt_s = CW'(OVS / 2);

    // Capture the two samples preceding the decision tick.
    always_comb begin
        vote_d = vote_q;
        if (sample_tick_i && !clear_i && (tick_cnt_q == VOTE_A || tick_cnt_q == VOTE_B)) begin
            vote_d = {vote_q[0], rx_sync_o};
        end else begin
            vote_d = vote_q;
        end
    end

    // Vote sample register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end

    assign bit_val_o = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_sync_o) | (vote_q[0] & rx_sync_o);
`else
    assign decide_cnt_s = CW'(OVS / 2 - 1);
    assign bit_val_o    = rx_sync_o;
`endif

    assign bit_sample_o = sample_tick_i & ~clear_i & (tick_cnt_q == decide_cnt_s);

endmodule

// File: rtl/uart_rx_frame_receiver.sv
// UART CRC-link receiver: frame FSM, parity/CRC/stop checks and valid/ready output register.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN (handled inside uart_rx_sampler).
module uart_rx_frame_receiver
    import uart_pkg::*;
#(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       sample_tick_i,
    input  logic       crc_en_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       parity_err_o,
    output logic       crc_err_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    rx_state_t  state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_sh_q, data_sh_d;
    logic [7:0] crc_sh_q, crc_sh_d;
    logic       crc_en_q, crc_en_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       commit_q, commit_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_out_q, perr_out_d;
    logic       cerr_out_q, cerr_out_d;
    logic       ferr_out_q, ferr_out_d;
    logic       overrun_q, overrun_d;
    logic       busy_q, busy_d;

    logic rx_sync_s, bit_sample_s, bit_val_s;

    uart_rx_sampler #(
        .OVS         (OVS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rx_i          (rx_i),
        .sample_tick_i (sample_tick_i),
        .clear_i       (state_q == RX_IDLE),
        .rx_sync_o     (rx_sync_s),
        .bit_sample_o  (bit_sample_s),
        .bit_val_o     (bit_val_s)
    );

    // Frame FSM next state and shift/check registers.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_sh_d = data_sh_q;
        crc_sh_d  = crc_sh_q;
        crc_en_d  = crc_en_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        commit_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                // Entry to IDLE always happens with the line high, so a low level here is a fall.
                if (sample_tick_i && !rx_sync_s) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (bit_sample_s) begin
                    if (bit_val_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d  = RX_DATA;
                        crc_en_d = crc_en_i;
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (bit_sample_s) begin
                    data_sh_d = {bit_val_s, data_sh_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (bit_sample_s) begin
                    perr_d  = bit_val_s ^ (^data_sh_q);
                    state_d = crc_en_q ? RX_CRC : RX_STOP;
                end else begin
                    state_d = RX_PARITY;
                end
            end
            RX_CRC: begin
                if (bit_sample_s) begin
                    crc_sh_d[bit_cnt_q[2:0]] = bit_val_s;
                    bit_cnt_d                = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        state_d = RX_CRC;
                    end
                end else begin
                    state_d = RX_CRC;
                end
            end
            RX_STOP: begin
                if (bit_sample_s) begin
                    ferr_d   = ~bit_val_s;
                    commit_d = 1'b1;
                    state_d  = bit_val_s ? RX_IDLE : RX_BREAK;
                end else begin
                    state_d = RX_STOP;
                end
            end
            RX_BREAK: begin
                if (sample_tick_i && rx_sync_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_BREAK;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            bit_cnt_d = 5'd0;
        end else begin
            bit_cnt_d = bit_cnt_d;
        end
    end

    // Output register: commit loads a new byte, a handshake retires it.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        cerr_out_d = cerr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;
        busy_d     = (state_d != RX_IDLE);
        if (commit_q) begin
            data_d     = data_sh_q;
            valid_d    = 1'b1;
            perr_out_d = perr_q;
            cerr_out_d = crc_en_q & (crc_sh_q != crc8_byte(data_sh_q));
            ferr_out_d = ferr_q;
            overrun_d  = valid_q & ~ready_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, shift and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RX_IDLE;
            bit_cnt_q  <= 5'd0;
            data_sh_q  <= 8'h00;
            crc_sh_q   <= 8'h00;
            crc_en_q   <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            commit_q   <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            cerr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_sh_q  <= data_sh_d;
            crc_sh_q   <= crc_sh_d;
            crc_en_q   <= crc_en_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            commit_q   <= commit_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            cerr_out_q <= cerr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_out_q;
    assign crc_err_o    = cerr_out_q;
    assign frame_err_o  = ferr_out_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = busy_q;

endmodule
